reg_alu_sequencer: RTL
======================

# reg_alu_sequencer

Instruction-driven control sequencer that issues register-read, ALU-operation and write-back control to the register-file/ALU datapath. It is the initiator for that datapath's control port: it accepts packed instructions over a valid/ready handshake and drives addresses, source select, ALU control, immediate data and write enable. It also returns the final ALU result with a one-cycle `done` pulse. It sits between an upstream instruction source (testbench, ROM or host) and the datapath.

## Interface
- `DATA_W`, 8, datapath/immediate width
- `ADDR_W`, 4, register address width
- `RPT_W`, 4, repeat-count width; instruction width `IW = RPT_W+4+3*ADDR_W+DATA_W` (28 at defaults)

- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `instr`  in  IW  packed instruction, MSB→LSB: `rpt[RPT_W]`, `op[2]`, `src[1]`, `we[1]`, `wa[ADDR_W]`, `ra1[ADDR_W]`, `ra2[ADDR_W]`, `imm[DATA_W]`
- `instr_valid`  in  1  upstream has an instruction
- `instr_ready`  out  1  sequencer accepts `instr` this cycle
- `ALUResult`  in  DATA_W  result returned by the datapath ALU
- `RA1`, `RA2`, `WA`  out  ADDR_W  datapath read/write addresses
- `external_data_in`  out  DATA_W  immediate operand
- `ALUSrc`  out  1  0 = second register operand, 1 = immediate
- `ALUControl`  out  2  ALU operation, passed through unmodified
- `RegWrite`  out  1  datapath write enable
- `busy`  out  1  high in EXEC
- `done`  out  1  one-cycle pulse after the final EXEC cycle
- `result`  out  DATA_W  `ALUResult` captured on the final EXEC cycle

## Operation
- FSM states are IDLE and EXEC. Reset leads to IDLE.
- IDLE: `instr_ready=1`. When `instr_valid&&instr_ready`, the instruction is latched into `cur`, the repeat counter is set to `cnt=rpt`, and the FSM moves to EXEC.
- EXEC: the control outputs drive the fields of `cur`, and `RegWrite=cur.we`.
  - Each EXEC cycle is one datapath operation. The write lands at the clock edge that ends the cycle.
  - When `cnt!=0`, the counter decrements and the FSM stays in EXEC.
  - When `cnt==0`, this is the final cycle. `result` captures `ALUResult`, `done` is set for the next cycle, and the FSM moves to IDLE (or to the next instruction, see Configuration).
- An instruction therefore executes `rpt+1` times; `rpt=0` gives a single operation.
  - Repeats with `wa==ra1` accumulate, e.g. add-immediate N+1 times.
  - Arithmetic wraps modulo 2^DATA_W inside the ALU; the sequencer performs no arithmetic on data.
- Outside EXEC: `RegWrite=0`. Address, immediate and ALU-control outputs hold the last `cur` values, so they are don't-care for the datapath.
- `instr` is sampled only on a handshake. Changes to `instr` while `instr_ready=0` are ignored.
- `result` holds its value until the next final EXEC cycle.

## Timing
- Reset values: `RA1=RA2=WA=0`, `external_data_in=0`, `ALUSrc=0`, `ALUControl=0`, `RegWrite=0`, `busy=0`, `done=0`, `result=0`, and `instr_ready=1` on the first cycle after `reset` deasserts.
- Latency: the handshake occurs in cycle T, the first EXEC cycle is T+1, and `done` is high in cycle T+rpt+2.
- `done` is a single-cycle pulse and is never asserted twice for one instruction.
- Reset during EXEC: in the cycle after the reset edge, `RegWrite=0` and the FSM is in IDLE. The remaining repeats are abandoned, no `done` pulse is produced, and `result` is cleared.
- Read-after-write between consecutive operations is safe. The write lands at the edge and the next cycle reads the updated register, because datapath reads are combinational.

## Configuration
- Macro: `REG_ALU_SEQUENCER_PIPE_EN`.
- Defined:
  - A one-entry instruction buffer is compiled in. `instr_ready=!buf_full`, including during EXEC.
  - In the final EXEC cycle, a buffered instruction (or one handshaken in that same cycle) is loaded into `cur`, giving back-to-back EXEC with no IDLE bubble. `done` still pulses for the completed instruction.
  - A buffered instruction is discarded on reset.
- Undefined:
  - `instr_ready=1` only in IDLE.
  - There is at least one IDLE cycle between instructions.

## Structure
- Package `reg_alu_pkg` holds the `DATA_W`/`ADDR_W`/`RPT_W` defaults, a packed `instr_t` struct matching the field order above, and the `state_t` enum {IDLE, EXEC}.
- Sub-module `instr_skid_buf` implements the one-entry buffer. It is instantiated only under `REG_ALU_SEQUENCER_PIPE_EN`.
- The FSM, repeat counter and result capture live in the top module.

## Test plan
- After reset: all outputs equal their reset values and `instr_ready=1` → handshake `ra1=2, op=ADD, src=1, imm=8'h05, we=1, wa=3, rpt=0` with R2=8'h10 → exactly one cycle with `RegWrite=1, WA=3, external_data_in=8'h05`. `done` pulses one cycle later with `result=8'h15`.
- Repeat accumulate: `rpt=3, wa=ra1=1, src=1, imm=1`, R1=0 → 4 EXEC cycles, R1=4, `result=8'h04`, one `done`.
- Wrap: R1=8'hFF, add imm 1, `rpt=0` → `result=8'h00`.
- Register source: R4=8'h07, R5=8'h09, `src=0`, add → `ALUSrc=0, RA2=5`, `result=8'h10`. A `we=0` variant keeps `RegWrite=0` throughout.
- Reset mid-run: assert `reset` on the 2nd of 4 repeats → `RegWrite=0` next cycle, no `done`, `result=0`.
- With `REG_ALU_SEQUENCER_PIPE_EN`: two back-to-back instructions → the second EXEC starts in the cycle immediately after the first's final cycle, and two `done` pulses are produced. Without the macro, one IDLE cycle separates them.

Source files
------------

// File: rtl/reg_alu_pkg.sv
// rtl/reg_alu_pkg.sv - shared widths, packed instruction layout and FSM states for reg_alu_sequencer
package reg_alu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_RPT_W  = 4;
    localparam int DEF_IW     = DEF_RPT_W + 4 + 3 * DEF_ADDR_W + DEF_DATA_W;

    // Field order is the wire order of the instr port, MSB first.
    typedef struct packed {
        logic [DEF_RPT_W-1:0]  rpt;
        logic [1:0]            op;
        logic                  src;
        logic                  we;
        logic [DEF_ADDR_W-1:0] wa;
        logic [DEF_ADDR_W-1:0] ra1;
        logic [DEF_ADDR_W-1:0] ra2;
        logic [DEF_DATA_W-1:0] imm;
    } instr_t;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/instr_skid_buf.sv
// rtl/instr_skid_buf.sv - one-entry instruction holding buffer used when REG_ALU_SEQUENCER_PIPE_EN is defined
module instr_skid_buf #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] in_data,
    output logic         full,
    output logic [W-1:0] out_data
);

    // The sequencer only pushes when empty and only pops when full.
    always_ff @(posedge clk) begin
        if (reset) begin
            full     <= 1'b0;
            out_data <= '0;
        end else if (push) begin
            full     <= 1'b1;
            out_data <= in_data;
        end else if (pop) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_alu_sequencer.sv
// rtl/reg_alu_sequencer.sv - instruction sequencer driving register-file/ALU control; REG_ALU_SEQUENCER_PIPE_EN enables back-to-back issue
module reg_alu_sequencer
    import reg_alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RPT_W  = DEF_RPT_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [RPT_W+3+3*ADDR_W+DATA_W:0]  instr,
    input  logic                              instr_valid,
    output logic                              instr_ready,
    input  logic [DATA_W-1:0]                 ALUResult,
    output logic [ADDR_W-1:0]                 RA1,
    output logic [ADDR_W-1:0]                 RA2,
    output logic [ADDR_W-1:0]                 WA,
    output logic [DATA_W-1:0]                 external_data_in,
    output logic                              ALUSrc,
    output logic [1:0]                        ALUControl,
    output logic                              RegWrite,
    output logic                              busy,
    output logic                              done,
    output logic [DATA_W-1:0]                 result
);

    state_t           state, state_n;
    instr_t           cur, next_instr;
    logic [RPT_W-1:0] cnt;
    logic             accept, load, last;

    assign last   = (state == EXEC) && (cnt == '0);
    assign accept = instr_valid && instr_ready;

`ifdef REG_ALU_SEQUENCER_PIPE_EN
    logic                buf_full, buf_push, buf_pop;
    logic [$bits(instr_t)-1:0] buf_data;

    // A waiting buffered instruction always has priority over the port.
    assign instr_ready = !buf_full;
    assign next_instr  = buf_full ? instr_t'(buf_data) : instr_t'(instr);
    assign load        = (buf_full || accept) && ((state == IDLE) || last);
    assign buf_pop     = load && buf_full;
    assign buf_push    = accept && (state == EXEC) && !last;

    instr_skid_buf #(.W($bits(instr_t))) u_skid (
        .clk      (clk),
        .reset    (reset),
        .push     (buf_push),
        .pop      (buf_pop),
        .in_data  (instr),
        .full     (buf_full),
        .out_data (buf_data)
    );
`else
    assign instr_ready = (state == IDLE);
    assign next_instr  = instr_t'(instr);
    assign load        = accept;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (load) state_n = EXEC;
            EXEC:    if (last) state_n = load ? EXEC : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= last;
            if (last) result <= ALUResult;
            if (load) begin
                cur <= next_instr;
                cnt <= next_instr.rpt;
            end else if ((state == EXEC) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign RA1              = cur.ra1;
    assign RA2              = cur.ra2;
    assign WA               = cur.wa;
    assign external_data_in = cur.imm;
    assign ALUSrc           = cur.src;
    assign ALUControl       = cur.op;
    assign busy             = (state == EXEC);
    assign RegWrite         = (state == EXEC) && cur.we;

endmodule
